// File: rtl/ucie_ctl_rx_pkg.sv
// Shared RDI link-state encodings, RX buffer FSM states and state-class helper.
package ucie_ctl_rx_pkg;

  localparam int unsigned STS_W = 4;

  localparam logic [STS_W-1:0] RDI_RESET     = 4'b0000;
  localparam logic [STS_W-1:0] RDI_ACTIVE    = 4'b0001;
  localparam logic [STS_W-1:0] RDI_PMNAK     = 4'b0011;
  localparam logic [STS_W-1:0] RDI_L1        = 4'b0100;
  localparam logic [STS_W-1:0] RDI_L2        = 4'b1000;
  localparam logic [STS_W-1:0] RDI_LINKRESET = 4'b1001;
  localparam logic [STS_W-1:0] RDI_LINKERROR = 4'b1010;
  localparam logic [STS_W-1:0] RDI_RETRAIN   = 4'b1011;
  localparam logic [STS_W-1:0] RDI_DISABLED  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    FLUSH  = 2'd3
  } rx_fsm_e;

  // Link states after which buffered flits are meaningless and must be discarded
  function automatic logic is_flush_state(input logic [STS_W-1:0] sts);
    return (sts == RDI_RESET) || (sts == RDI_LINKRESET) ||
           (sts == RDI_LINKERROR) || (sts == RDI_DISABLED);
  endfunction

endpackage

// File: rtl/ucie_ctl_rdi_rx_buffer_if.sv
// RDI receive side and FDI delivery side of the RX buffer.
interface ucie_ctl_rdi_rx_buffer_if #(
  parameter int unsigned NBYTES = 8
);
  import ucie_ctl_rx_pkg::*;

  localparam int unsigned DW = NBYTES * 8;

  logic [STS_W-1:0] rdi_pl_state_sts;
  logic             rdi_pl_valid;
  logic [DW-1:0]    rdi_pl_data;
  logic             rdi_lp_irdy;
  logic             fdi_lp_irdy;
  logic [DW-1:0]    fdi_data;
  logic             fdi_data_valid;

  // PHY/adapter side: drives received flits and FDI ready
  modport master (
    output rdi_pl_state_sts, rdi_pl_valid, rdi_pl_data, fdi_lp_irdy,
    input  rdi_lp_irdy, fdi_data, fdi_data_valid
  );

  // Buffer side
  modport slave (
    input  rdi_pl_state_sts, rdi_pl_valid, rdi_pl_data, fdi_lp_irdy,
    output rdi_lp_irdy, fdi_data, fdi_data_valid
  );

endinterface

// File: rtl/ucie_ctl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
module ucie_ctl_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // When full, a write is only possible if the head leaves in the same cycle
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == LW'(0));
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + LW'(1);
      if (rd_en) rd_ptr <= rd_ptr + LW'(1);
    end
  end

  // Storage write; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ucie_ctl_rdi_rx_buffer.sv
// RX buffer between PHY RDI receive path and adapter FDI: link-state gated FIFO with drop accounting.
module ucie_ctl_rdi_rx_buffer
  import ucie_ctl_rx_pkg::*;
#(
  parameter int unsigned NBYTES    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned DROP_CW   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  ucie_ctl_rdi_rx_buffer_if.slave  rx,
  input  logic                     i_clr_overflow,
  output logic                     o_overflow_detected,
  output logic [DROP_CW-1:0]       o_drop_count,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic [1:0]               o_rx_state
);

  localparam int unsigned DW = NBYTES * 8;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  rx_fsm_e          state;
  rx_fsm_e          state_nxt;
  logic             push;
  logic             pop;
  logic             drop;
  logic             flush;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic [DW-1:0]    head;
  logic [STS_W-1:0] sts;

  assign sts   = rx.rdi_pl_state_sts;
  assign push  = rx.rdi_pl_valid & (state == ACTIVE);
  assign flush = (state == FLUSH);
  assign pop   = rx.fdi_data_valid & rx.fdi_lp_irdy;
  assign drop  = push & full & ~pop;

  assign rx.fdi_data_valid = ~empty & ((state == ACTIVE) | (state == DRAIN));
  assign rx.fdi_data       = rx.fdi_data_valid ? head : '0;
  assign rx.rdi_lp_irdy    = (level < LW'(AF_THRESH)) & (state == ACTIVE);

  assign o_fifo_level = level;
  assign o_rx_state   = 2'(state);

  ucie_ctl_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (rx.rdi_pl_data),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: flush-class status beats ACTIVE status beats drain completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sts == RDI_ACTIVE) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (is_flush_state(sts))    state_nxt = FLUSH;
        else if (sts != RDI_ACTIVE) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (is_flush_state(sts))    state_nxt = FLUSH;
        else if (sts == RDI_ACTIVE) state_nxt = ACTIVE;
        else if (empty)             state_nxt = IDLE;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky overflow and saturating drop count; a drop in the clear cycle survives the clear
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      o_overflow_detected <= 1'b0;
      o_drop_count        <= '0;
    end else if (i_clr_overflow) begin
      o_overflow_detected <= drop;
      o_drop_count        <= DROP_CW'(drop);
    end else if (drop) begin
      o_overflow_detected <= 1'b1;
      if (o_drop_count != '1) o_drop_count <= o_drop_count + DROP_CW'(1);
    end
  end

endmodule

// File: tb/tb_ucie_ctl_rdi_rx_buffer.sv
// Directed bench: stimulus queues expected FDI flits, a negedge monitor checks each handshake.
module tb_ucie_ctl_rdi_rx_buffer;
  import ucie_ctl_rx_pkg::*;

  localparam int unsigned NBYTES = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF     = 12;
  localparam int unsigned DCW    = 8;
  localparam int unsigned DW     = NBYTES * 8;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           clr;
  logic           overflow;
  logic [DCW-1:0] drop_count;
  logic [LW-1:0]  level;
  logic [1:0]     rx_state;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  ucie_ctl_rdi_rx_buffer_if #(.NBYTES(NBYTES)) bus ();

  ucie_ctl_rdi_rx_buffer #(
    .NBYTES    (NBYTES),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .DROP_CW   (DCW)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .rx                  (bus),
    .i_clr_overflow      (clr),
    .o_overflow_detected (overflow),
    .o_drop_count        (drop_count),
    .o_fifo_level        (level),
    .o_rx_state          (rx_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] d, input bit expect_out);
    bus.rdi_pl_valid = 1'b1;
    bus.rdi_pl_data  = d;
    if (expect_out) exp_q.push_back(d);
    step();
    bus.rdi_pl_valid = 1'b0;
  endtask

  // Scoreboard monitor: every FDI handshake must deliver the oldest expected flit
  always @(negedge clk) begin
    if (!rst && bus.fdi_data_valid && bus.fdi_lp_irdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL fdi_unexpected: got %0h expected none", bus.fdi_data);
      end else begin
        check("fdi_data", 64'(bus.fdi_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.rdi_pl_state_sts = RDI_RESET;
    bus.rdi_pl_valid     = 1'b0;
    bus.rdi_pl_data      = '0;
    bus.fdi_lp_irdy      = 1'b0;
    step();
    step();
    check("rst_level", 64'(level), 64'(0));
    check("rst_valid", 64'(bus.fdi_data_valid), 64'(0));
    check("rst_state", 64'(rx_state), 64'(IDLE));
    check("rst_irdy",  64'(bus.rdi_lp_irdy), 64'(0));
    check("rst_ovf",   64'(overflow), 64'(0));
    check("rst_cnt",   64'(drop_count), 64'(0));

    // 1) three flits stream straight through
    rst = 1'b0;
    bus.rdi_pl_state_sts = RDI_ACTIVE;
    step();
    check("t1_state", 64'(rx_state), 64'(ACTIVE));
    check("t1_irdy",  64'(bus.rdi_lp_irdy), 64'(1));
    bus.fdi_lp_irdy = 1'b1;
    push_one(64'hAAAA_0000_0000_000A, 1'b1);
    check("t1_lat_valid", 64'(bus.fdi_data_valid), 64'(1));
    check("t1_lat_level", 64'(level), 64'(1));
    push_one(64'hBBBB_0000_0000_000B, 1'b1);
    push_one(64'hCCCC_0000_0000_000C, 1'b1);
    step();
    check("t1_level_end", 64'(level), 64'(0));
    check("t1_valid_end", 64'(bus.fdi_data_valid), 64'(0));

    // 2) fill to full with backpressure, then two drops
    bus.fdi_lp_irdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_one({32'hD000_0000, 32'(i)}, 1'b1);
      if (i == 10) check("t2_irdy_l11", 64'(bus.rdi_lp_irdy), 64'(1));
      if (i == 11) check("t2_irdy_l12", 64'(bus.rdi_lp_irdy), 64'(0));
    end
    push_one(64'hDEAD_0000_0000_0001, 1'b0);
    push_one(64'hDEAD_0000_0000_0002, 1'b0);
    check("t2_level", 64'(level), 64'(16));
    check("t2_ovf",   64'(overflow), 64'(1));
    check("t2_cnt",   64'(drop_count), 64'(2));

    // 3) push with pop while full is accepted; then clear, then drop during clear
    bus.fdi_lp_irdy = 1'b1;
    push_one(64'hEEEE_0000_0000_000E, 1'b1);
    bus.fdi_lp_irdy = 1'b0;
    check("t3_level", 64'(level), 64'(16));
    check("t3_cnt",   64'(drop_count), 64'(2));
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t3_clr_ovf", 64'(overflow), 64'(0));
    check("t3_clr_cnt", 64'(drop_count), 64'(0));
    clr = 1'b1;
    push_one(64'hDEAD_0000_0000_0003, 1'b0);
    clr = 1'b0;
    check("t3_clrdrop_ovf", 64'(overflow), 64'(1));
    check("t3_clrdrop_cnt", 64'(drop_count), 64'(1));
    bus.fdi_lp_irdy = 1'b1;
    repeat (16) step();
    bus.fdi_lp_irdy = 1'b0;
    check("t3_drained", 64'(level), 64'(0));
    check("t3_q_empty", 64'(exp_q.size()), 64'(0));

    // 4) L1 drains buffered flits, ignores new pushes, then returns to IDLE
    for (int i = 0; i < 5; i++) push_one({32'hF000_0000, 32'(i)}, 1'b1);
    bus.rdi_pl_state_sts = RDI_L1;
    step();
    check("t4_state_drain", 64'(rx_state), 64'(DRAIN));
    check("t4_irdy", 64'(bus.rdi_lp_irdy), 64'(0));
    bus.rdi_pl_valid = 1'b1;
    bus.rdi_pl_data  = 64'hBAD0_0000_0000_0004;
    bus.fdi_lp_irdy  = 1'b1;
    for (int k = 0; k < 20 && rx_state != 2'(IDLE); k++) step();
    bus.rdi_pl_valid = 1'b0;
    bus.fdi_lp_irdy  = 1'b0;
    check("t4_state_idle", 64'(rx_state), 64'(IDLE));
    check("t4_level", 64'(level), 64'(0));
    check("t4_cnt", 64'(drop_count), 64'(1));
    check("t4_q_empty", 64'(exp_q.size()), 64'(0));

    // 5) LINKERROR flushes buffered flits in one cycle; push works again afterwards
    bus.rdi_pl_state_sts = RDI_ACTIVE;
    step();
    check("t5_state_active", 64'(rx_state), 64'(ACTIVE));
    for (int i = 0; i < 5; i++) push_one({32'h6000_0000, 32'(i)}, 1'b0);
    check("t5_level5", 64'(level), 64'(5));
    bus.rdi_pl_state_sts = RDI_LINKERROR;
    step();
    check("t5_state_flush", 64'(rx_state), 64'(FLUSH));
    check("t5_flush_valid", 64'(bus.fdi_data_valid), 64'(0));
    step();
    check("t5_state_idle", 64'(rx_state), 64'(IDLE));
    check("t5_level0", 64'(level), 64'(0));
    check("t5_cnt0", 64'(drop_count), 64'(0));
    check("t5_ovf0", 64'(overflow), 64'(0));
    bus.rdi_pl_state_sts = RDI_ACTIVE;
    step();
    bus.fdi_lp_irdy = 1'b1;
    push_one(64'h1234_5678_9ABC_DEF0, 1'b1);
    check("t5_repush_valid", 64'(bus.fdi_data_valid), 64'(1));
    check("t5_repush_data", 64'(bus.fdi_data), 64'h1234_5678_9ABC_DEF0);
    step();
    bus.fdi_lp_irdy = 1'b0;
    check("t5_repush_level", 64'(level), 64'(0));

    // 6) drop counter saturation, then reset mid-stream
    for (int i = 0; i < 16; i++) push_one({32'h7000_0000, 32'(i)}, 1'b0);
    for (int i = 0; i < 300; i++) begin
      push_one({32'h8000_0000, 32'(i)}, 1'b0);
      if (i == 253) check("t6_cnt254", 64'(drop_count), 64'(254));
      if (i == 254) check("t6_cnt255", 64'(drop_count), 64'(255));
    end
    check("t6_cnt_sat", 64'(drop_count), 64'(255));
    check("t6_ovf", 64'(overflow), 64'(1));
    bus.rdi_pl_valid = 1'b1;
    bus.rdi_pl_data  = 64'h9999_0000_0000_0009;
    rst = 1'b1;
    step();
    check("t6_rst_level", 64'(level), 64'(0));
    check("t6_rst_valid", 64'(bus.fdi_data_valid), 64'(0));
    check("t6_rst_data",  64'(bus.fdi_data), 64'(0));
    check("t6_rst_ovf",   64'(overflow), 64'(0));
    check("t6_rst_cnt",   64'(drop_count), 64'(0));
    check("t6_rst_state", 64'(rx_state), 64'(IDLE));
    check("t6_rst_irdy",  64'(bus.rdi_lp_irdy), 64'(0));
    rst = 1'b0;
    bus.rdi_pl_valid = 1'b0;
    step();
    check("end_q_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
